// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, registers the fetched word into IF/ID,
// and redirects on branches, interrupt entry and return-from-interrupt.
module if_fetch #(
  parameter int              CPU_WIDTH  = 16,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = 16'h0000,
  parameter logic [CPU_WIDTH-1:0] INT_VECTOR = 16'h0004,
  parameter logic [CPU_WIDTH-1:0] NOP_INSTR  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 jump_flag,
  input  logic [CPU_WIDTH-1:0] jump_addr,
  input  logic                 int_req,
  input  logic                 reti,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0] imem_data,
  output logic [CPU_WIDTH-1:0] if_pc,
  output logic [CPU_WIDTH-1:0] if_instr,
  output logic                 if_valid,
  output logic                 flush_id,
  output logic [CPU_WIDTH-1:0] epc,
  output logic                 int_active,
  output logic                 int_ack
);

  typedef struct packed {
    logic [CPU_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0] instr;
    logic                 valid;
  } ifid_t;

  logic [CPU_WIDTH-1:0] pc;
  ifid_t                ifid;
  logic                 take_ret;
  logic                 take_int;

  always_comb begin
    imem_addr = pc;
    flush_id  = jump_flag & ~rst;
    take_ret  = reti & int_active;
    // entry waits out branches, returns and stalls; int_req is a level so it stays pending
    take_int  = int_req & ~int_active & ~stall & ~jump_flag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      ifid.pc    <= '0;
      ifid.instr <= NOP_INSTR;
      ifid.valid <= 1'b0;
      epc        <= '0;
      int_active <= 1'b0;
      int_ack    <= 1'b0;
    end else begin
      int_ack <= 1'b0;
      if (jump_flag) begin
        pc         <= jump_addr;
        ifid.instr <= NOP_INSTR;
        ifid.valid <= 1'b0;
      end else if (take_ret) begin
        pc         <= epc;
        int_active <= 1'b0;
        ifid.instr <= NOP_INSTR;
        ifid.valid <= 1'b0;
      end else if (take_int) begin
        epc        <= pc;
        pc         <= INT_VECTOR;
        int_active <= 1'b1;
        int_ack    <= 1'b1;
        ifid.instr <= NOP_INSTR;
        ifid.valid <= 1'b0;
      end else if (!stall) begin
        ifid.instr <= imem_data;
        ifid.pc    <= pc;
        ifid.valid <= 1'b1;
        pc         <= pc + 1'b1;
      end
    end
  end

  assign if_pc    = ifid.pc;
  assign if_instr = ifid.instr;
  assign if_valid = ifid.valid;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 16-bit pipelined interrupt-capable CPU.
- Owns the program counter and drives the instruction-memory address. Registers the fetched instruction into the IF/ID boundary.
- Consumes the branch decision produced by the execute stage: jump_flag plus target. Also handles interrupt entry and return redirection.

Parameters:
- CPU_WIDTH, 16, datapath, PC and instruction width.
- RESET_PC, 16'h0000, PC value after reset.
- INT_VECTOR, 16'h0004, PC loaded on interrupt entry.
- NOP_INSTR, 16'h0000, instruction word injected on flush.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard hold; freezes PC and the IF/ID registers.
- jump_flag  in  1  taken-branch indication from the execute stage.
- jump_addr  in  CPU_WIDTH  branch target, valid when jump_flag=1.
- int_req  in  1  level interrupt request.
- reti  in  1  one-cycle pulse from decode: return from interrupt.
- imem_addr  out  CPU_WIDTH  instruction-memory address; equals the PC register.
- imem_data  in  CPU_WIDTH  instruction word; combinational read of imem_addr in the same cycle.
- if_pc  out  CPU_WIDTH  PC of the instruction in if_instr.
- if_instr  out  CPU_WIDTH  registered instruction to decode.
- if_valid  out  1  if_instr is a real instruction, not a bubble.
- flush_id  out  1  kill the instruction currently in decode.
- epc  out  CPU_WIDTH  saved return PC.
- int_active  out  1  an interrupt handler is executing.
- int_ack  out  1  one-cycle pulse on interrupt entry.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, if_pc=0, if_instr=NOP_INSTR, if_valid=0.
  - epc=0, int_active=0, int_ack=0.
  - Reset has priority over every other input.
- imem_addr = pc combinationally.
- flush_id = jump_flag & ~rst, combinational.
- Per-edge priority (first match wins):
  1. rst.
  2. jump_flag: pc<=jump_addr; if_instr<=NOP_INSTR; if_valid<=0. Overrides stall, so a redirect is never lost.
  3. reti & int_active: pc<=epc; int_active<=0; if_instr<=NOP_INSTR; if_valid<=0.
  4. int_req & ~int_active & ~stall: epc<=pc; pc<=INT_VECTOR; int_active<=1; int_ack<=1; if_instr<=NOP_INSTR; if_valid<=0.
  5. stall: pc, if_pc, if_instr, if_valid all hold.
  6. Otherwise: if_instr<=imem_data; if_pc<=pc; if_valid<=1; pc<=pc+1.
- int_ack is 1 only in the cycle after an entry edge; otherwise 0.
- reti while int_active=0 is ignored; that edge takes rule 5 or 6.
- No nesting: int_req is ignored while int_active=1, and stays pending as a level until the handler returns.
- Interrupt coinciding with jump_flag is deferred. Entry happens on the first later edge where rules 1–3 do not apply and stall=0. epc therefore captures the post-branch target.
- Interrupt during stall is deferred until stall deasserts.
- epc is the next unfetched PC. Instructions already past IF complete normally.
- Arithmetic: pc+1 is modulo 2^CPU_WIDTH, so 16'hFFFF wraps to 16'h0000 with no flag.
- Latency: an instruction at address A appears on if_instr one edge after pc=A, when not stalled.
- Branch penalty: 2 bubbles. One is the if_valid=0 slot; the other is the decode kill via flush_id.

Test Plan:
- Reset then 4 free-running cycles, imem_data=addr^16'hA5A5 → if_pc 0,1,2,3; if_instr 16'hA5A5,16'hA5A4,16'hA5A7,16'hA5A6; if_valid=1 from cycle 1.
- stall=1 for 3 cycles at pc=5 → imem_addr stays 5 and if_pc/if_instr/if_valid frozen; fetch of address 5 follows release.
- jump_flag=1, jump_addr=16'h0040, with stall=1 in the same cycle → flush_id=1 that cycle; next edge pc=16'h0040, if_valid=0, if_instr=NOP_INSTR; address 16'h0040 fetched on the following edge.
- int_req=1 at pc=16'h0012 → epc=16'h0012, pc=INT_VECTOR, int_ack high exactly one cycle, int_active=1. A second int_req while active is ignored. reti → pc=16'h0012, int_active=0.
- int_req and jump_flag (jump_addr=16'h0030) in the same cycle → the jump is taken first; entry occurs one edge later with epc=16'h0030.
- pc=16'hFFFF with no events → next pc=16'h0000. rst asserted while int_active=1 → all outputs return to reset values on that edge.
